hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Stall and bubble controller paired with the EX-stage forwarding unit in the 5-stage RISC-V pipeline. The forwarding unit only covers ALU results (`mem_2_reg` = 0). This block covers the remaining cases:

- **Load-use:** load results are never forwarded, so the block holds a dependent instruction in ID until the load reaches WB.
- **Multi-cycle multiply:** the block freezes the front of the pipeline while a multiply occupies EX for `MULT_LATENCY` cycles.

It drives the PC, IF/ID and ID/EX write enables and the bubble-insert controls of ID/EX and EX/MEM.

## Interface
Parameters:
- `MULT_LATENCY`, default 3: cycles a multiply occupies EX. Legal range is 1..16.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rs1_ID`, `rs2_ID` in 5 each: source registers of the instruction in ID.
- `uses_rs1_ID`, `uses_rs2_ID` in 1 each: the ID instruction actually reads rs1 / rs2.
- `rd_ID_EX`, `reg_write_EX`, `mem_2_reg_EX` in 5/1/1: destination, write flag and load flag of the instruction in EX.
- `rd_EX_MEM`, `reg_write_MEM`, `mem_2_reg_MEM` in 5/1/1: the same fields for the instruction in MEM.
- `mult_EX` in 1: a valid (non-bubble) multiply is in EX.
- `pc_en` out 1: PC write enable.
- `if_id_en` out 1: IF/ID write enable.
- `id_ex_en` out 1: ID/EX write enable.
- `id_ex_bubble` out 1: load a NOP into ID/EX.
- `ex_mem_bubble` out 1: load a NOP into EX/MEM.
- `mult_start` out 1: one-cycle pulse that starts the multiplier.
- `mult_busy` out 1: high while the multiplier result is not ready.
- `load_stall_cnt`, `mult_stall_cnt` out 32 each: stall statistics (see Configuration).

## Operation
Match terms:
- `match(rd)` = `rd != 0` & ((`uses_rs1_ID` & `rs1_ID == rd`) | (`uses_rs2_ID` & `rs2_ID == rd`)).
- `load_hazard` = (`reg_write_EX` & `mem_2_reg_EX` & `match(rd_ID_EX)`) | (`reg_write_MEM` & `mem_2_reg_MEM` & `match(rd_EX_MEM)`).
- A load in WB needs no stall: the register file is write-first, so ID reads the new value.

FSM states:
- **IDLE:**
  - If `mult_EX` and `MULT_LATENCY` ≥ 2: assert `mult_start` and `mult_busy`, drive `pc_en`/`if_id_en`/`id_ex_en` = 0 and `ex_mem_bubble` = 1, load `cnt` = `MULT_LATENCY`−2, go to BUSY.
  - If `mult_EX` and `MULT_LATENCY` = 1: assert `mult_start` only; no stall.
- **BUSY, `cnt` > 0:** same stall outputs as the IDLE multiply entry, without `mult_start`; `cnt` decrements.
- **BUSY, `cnt` = 0:** release cycle. `mult_busy` = 0, `ex_mem_bubble` = 0, the multiply result advances into EX/MEM, go to IDLE.

Outputs when no multiply stall is active (IDLE without a multiply stall, or the BUSY release cycle):
- If `load_hazard`: `pc_en` = 0, `if_id_en` = 0, `id_ex_en` = 1, `id_ex_bubble` = 1.
- Otherwise: all enables = 1, both bubbles = 0.

Priority and boundaries:
- A multiply stall overrides a load hazard. ID/EX is frozen, so no bubble is inserted and the hazard is re-evaluated on the release cycle.
- `rd` = x0 never stalls.
- A load in both EX and MEM matching different sources gives a single stall condition, held until both loads clear MEM.
- Back-to-back multiplies: the release cycle moves the next multiply into EX, and it is detected in IDLE on the following cycle.

## Timing
- All outputs are combinational from state and inputs. State is `state` and a 4-bit `cnt`.
- Multiply: with `MULT_LATENCY` = L, the front is frozen for L−1 cycles, and the multiply leaves EX at the end of cycle L (cycle 1 = first cycle in EX).
- Load-use penalty:
  - 2 cycles if the load is in EX when the dependent instruction enters ID.
  - 1 cycle if the load is in MEM.
- Reset:
  - While `rst` = 1: `pc_en`/`if_id_en`/`id_ex_en` = 1, bubbles = 0, `mult_start` = `mult_busy` = 0.
  - On the next edge: `state` = IDLE, `cnt` = 0, counters = 0.
  - Reset during BUSY aborts the multiply immediately.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `load_stall_cnt` increments on every cycle with `load_hazard` & not multiply-stalled.
  - `mult_stall_cnt` increments on every cycle with `mult_busy` = 1.
  - Both counters saturate at 0xFFFFFFFF and are cleared by `rst`.
- Undefined: no counter registers; both outputs are tied to 0.

## Test plan
- **Load in EX:** `rd_ID_EX` = 5 with `mem_2_reg_EX` = 1 and `rs1_ID` = 5 → cycle 1 `pc_en` = 0, `id_ex_bubble` = 1; load then in MEM → cycle 2 same; cycle 3 all enables = 1.
- **Load to x0:** `rd_ID_EX` = 0 with `mem_2_reg_EX` = 1 and `rs1_ID` = 0 → no stall.
- **Multiply, `MULT_LATENCY` = 3:** `mult_EX` = 1 → `mult_start` pulse in cycle 1; `mult_busy` = 1 and `ex_mem_bubble` = 1 in cycles 1–2; cycle 3 all enables = 1; `mult_stall_cnt` = 2 with `HAZARD_STATS_EN`.
- **Multiply with pending load-use:** multiply in EX and load `rd_EX_MEM` = 7 matching `rs2_ID` → no `id_ex_bubble` during BUSY; load has left MEM by release, so the release cycle has no stall.
- **`MULT_LATENCY` = 1:** `mult_EX` = 1 → `mult_start` = 1, `mult_busy` = 0, no stall.
- **Reset mid-multiply:** `rst` high in BUSY with `cnt` = 1 → next cycle `state` = IDLE, `mult_busy` = 0, all enables = 1, counters = 0.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//
// Stall and bubble controller for the 5-stage RISC-V pipeline. It works
// alongside the EX-stage forwarding unit and handles the hazards that
// forwarding cannot resolve:
//   - load-use: a load result is never forwarded. A dependent instruction
//     is held in ID until the load reaches WB. The register file is
//     write-first, so ID reads the new value in that cycle.
//   - multi-cycle multiply: the front of the pipeline is frozen while a
//     multiply occupies EX for MULT_LATENCY cycles.
//
// Optional feature macro: HAZARD_STATS_EN
//   When defined, the unit has saturating stall-statistics counters.
//   When undefined, both counter outputs are tied to zero.
//
// Parameters:
//   MULT_LATENCY   cycles a multiply occupies EX (legal range 1..16)
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   rs1_ID, rs2_ID                   source registers of the ID instruction
//   uses_rs1_ID, uses_rs2_ID         ID instruction really reads rs1 / rs2
//   rd_ID_EX, reg_write_EX,
//   mem_2_reg_EX                     destination / write / load flag in EX
//   rd_EX_MEM, reg_write_MEM,
//   mem_2_reg_MEM                    destination / write / load flag in MEM
//   mult_EX                          a valid multiply is in EX
//   pc_en, if_id_en, id_ex_en        pipeline register write enables
//   id_ex_bubble, ex_mem_bubble      load a NOP into ID/EX or EX/MEM
//   mult_start                       one-cycle pulse that starts the multiplier
//   mult_busy                        multiplier result is not ready yet
//   load_stall_cnt, mult_stall_cnt   stall statistics (zero when disabled)

module hazard_stall_unit #(
    parameter int MULT_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_ID,
    input  logic [4:0]  rs2_ID,
    input  logic        uses_rs1_ID,
    input  logic        uses_rs2_ID,
    input  logic [4:0]  rd_ID_EX,
    input  logic        reg_write_EX,
    input  logic        mem_2_reg_EX,
    input  logic [4:0]  rd_EX_MEM,
    input  logic        reg_write_MEM,
    input  logic        mem_2_reg_MEM,
    input  logic        mult_EX,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        id_ex_bubble,
    output logic        ex_mem_bubble,
    output logic        mult_start,
    output logic        mult_busy,
    output logic [31:0] load_stall_cnt,
    output logic [31:0] mult_stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // A single-cycle multiply needs no freeze, so no BUSY phase.
    localparam bit LONG_MULT = (MULT_LATENCY >= 2);

    // The entry cycle and the release cycle are not counted in BUSY, so the
    // counter starts at L-2.
    localparam logic [3:0] CNT_LOAD = LONG_MULT ? 4'(MULT_LATENCY - 2) : 4'd0;

    state_t     r_state;
    logic [3:0] r_cnt;

    logic w_match_ex;
    logic w_match_mem;
    logic w_load_hazard;
    logic w_mult_stall;

    // x0 is hardwired to zero, so a write to it can never create a dependency.
    assign w_match_ex  = (rd_ID_EX != 5'd0) &&
                         ((uses_rs1_ID && (rs1_ID == rd_ID_EX)) ||
                          (uses_rs2_ID && (rs2_ID == rd_ID_EX)));
    assign w_match_mem = (rd_EX_MEM != 5'd0) &&
                         ((uses_rs1_ID && (rs1_ID == rd_EX_MEM)) ||
                          (uses_rs2_ID && (rs2_ID == rd_EX_MEM)));

    // A load in either EX or MEM blocks its consumer. One combined term is
    // enough, because the stall holds until both loads have left MEM.
    assign w_load_hazard = (reg_write_EX  && mem_2_reg_EX  && w_match_ex) ||
                           (reg_write_MEM && mem_2_reg_MEM && w_match_mem);

    // The freeze covers the IDLE entry cycle and every BUSY cycle except the
    // final release cycle (cnt = 0).
    assign w_mult_stall = ((r_state == IDLE) && mult_EX && LONG_MULT) ||
                          ((r_state == BUSY) && (r_cnt != 4'd0));

    // Output decode. A multiply freeze has priority over a load hazard.
    // ID/EX is frozen during the freeze, so no bubble is needed, and the
    // load hazard is checked again on the release cycle.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mult_start    = 1'b0;
        mult_busy     = 1'b0;
        if (!rst) begin
            mult_start = (r_state == IDLE) && mult_EX;
            if (w_mult_stall) begin
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                ex_mem_bubble = 1'b1;
                mult_busy     = 1'b1;
            end else if (w_load_hazard) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    // Multiply sequencer. In BUSY, mult_EX is ignored because the same
    // multiply is still in EX. A following multiply is detected in IDLE,
    // one cycle after the release cycle has moved it into EX. Reset aborts
    // a multiply that is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mult_EX && LONG_MULT) begin
                        r_state <= BUSY;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_load_stall_cnt;
    logic [31:0] r_mult_stall_cnt;
    logic        w_load_stall_cycle;

    // Count a load stall only when the load hazard is really the cause.
    // A cycle frozen by a multiply counts as a multiply stall.
    assign w_load_stall_cycle = w_load_hazard && !w_mult_stall;

    // Saturating counters, so a long run never wraps back to small values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_stall_cnt <= 32'd0;
            r_mult_stall_cnt <= 32'd0;
        end else begin
            if (w_load_stall_cycle && (r_load_stall_cnt != 32'hFFFF_FFFF)) begin
                r_load_stall_cnt <= r_load_stall_cnt + 32'd1;
            end
            if (mult_busy && (r_mult_stall_cnt != 32'hFFFF_FFFF)) begin
                r_mult_stall_cnt <= r_mult_stall_cnt + 32'd1;
            end
        end
    end

    assign load_stall_cnt = r_load_stall_cnt;
    assign mult_stall_cnt = r_mult_stall_cnt;
`else
    assign load_stall_cnt = 32'd0;
    assign mult_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit
//
// Testbench for hazard_stall_unit. It uses two instances that share all
// inputs: one with MULT_LATENCY = 3 and one with MULT_LATENCY = 1.
// A behavioural model tracks how many cycles the current multiply has
// spent in EX. On every negative edge it checks both instances. Directed
// vectors reproduce the pipeline scenarios and add hand-computed literal
// expectations.

module tb_hazard_stall_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1ID, rs2ID;
    logic        usesRs1, usesRs2;
    logic [4:0]  rdEx, rdMem;
    logic        regWriteEx, memToRegEx, regWriteMem, memToRegMem;
    logic        multEx;

    logic        pcEn3, ifIdEn3, idExEn3, idExBub3, exMemBub3, start3, busy3;
    logic [31:0] loadCnt3, multCnt3;
    logic        pcEn1, ifIdEn1, idExEn1, idExBub1, exMemBub1, start1, busy1;
    logic [31:0] loadCnt1, multCnt1;

    int checks = 0;
    int errors = 0;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic       pc;
        logic       ifId;
        logic       idEx;
        logic       idExBub;
        logic       exMemBub;
        logic       start;
        logic       busy;
        logic       stallMult;
        logic [4:0] nextAge;
    } exp_t;

    // Model state: cycles the tracked multiply has spent in EX (0 = none),
    // and the stall counters for each instance.
    logic [4:0]  age3 = 5'd0, age1 = 5'd0;
    logic [31:0] mLoad3 = 32'd0, mMult3 = 32'd0, mLoad1 = 32'd0, mMult1 = 32'd0;

    hazard_stall_unit #(.MULT_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .rs1_ID(rs1ID), .rs2_ID(rs2ID),
        .uses_rs1_ID(usesRs1), .uses_rs2_ID(usesRs2),
        .rd_ID_EX(rdEx), .reg_write_EX(regWriteEx), .mem_2_reg_EX(memToRegEx),
        .rd_EX_MEM(rdMem), .reg_write_MEM(regWriteMem), .mem_2_reg_MEM(memToRegMem),
        .mult_EX(multEx),
        .pc_en(pcEn3), .if_id_en(ifIdEn3), .id_ex_en(idExEn3),
        .id_ex_bubble(idExBub3), .ex_mem_bubble(exMemBub3),
        .mult_start(start3), .mult_busy(busy3),
        .load_stall_cnt(loadCnt3), .mult_stall_cnt(multCnt3)
    );

    hazard_stall_unit #(.MULT_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .rs1_ID(rs1ID), .rs2_ID(rs2ID),
        .uses_rs1_ID(usesRs1), .uses_rs2_ID(usesRs2),
        .rd_ID_EX(rdEx), .reg_write_EX(regWriteEx), .mem_2_reg_EX(memToRegEx),
        .rd_EX_MEM(rdMem), .reg_write_MEM(regWriteMem), .mem_2_reg_MEM(memToRegMem),
        .mult_EX(multEx),
        .pc_en(pcEn1), .if_id_en(ifIdEn1), .id_ex_en(idExEn1),
        .id_ex_bubble(idExBub1), .ex_mem_bubble(exMemBub1),
        .mult_start(start1), .mult_busy(busy1),
        .load_stall_cnt(loadCnt1), .mult_stall_cnt(multCnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // True when the ID instruction reads register r (r nonzero).
    function automatic logic readsReg(input logic [4:0] r);
        return (r != 5'd0) && ((usesRs1 && rs1ID == r) || (usesRs2 && rs2ID == r));
    endfunction

    function automatic logic loadHazardNow();
        return (regWriteEx && memToRegEx && readsReg(rdEx)) ||
               (regWriteMem && memToRegMem && readsReg(rdMem));
    endfunction

    // Cycle c of a multiply in EX (1-based). The front is frozen for cycles
    // 1..L-1. Cycle L releases it. The start pulse appears only when no
    // multiply is being tracked.
    function automatic exp_t modelStep(input int lat, input logic [4:0] age,
                                       input logic hazard, input logic multIn,
                                       input logic rstIn);
        exp_t e;
        int   c;
        e = '0;
        e.pc = 1'b1; e.ifId = 1'b1; e.idEx = 1'b1;
        if (!rstIn) begin
            if (age != 5'd0) c = int'(age) + 1;
            else if (multIn) c = 1;
            else c = 0;
            e.start     = (age == 5'd0) && multIn;
            e.stallMult = (c >= 1) && (c <= lat - 1);
            e.busy      = e.stallMult;
            if (e.stallMult) begin
                e.pc = 1'b0; e.ifId = 1'b0; e.idEx = 1'b0;
                e.exMemBub = 1'b1;
                e.nextAge  = 5'(c);
            end else if (hazard) begin
                e.pc = 1'b0; e.ifId = 1'b0; e.idExBub = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareDut(input string tag, input exp_t e,
                              input logic pc, input logic ifId, input logic idEx,
                              input logic idExBub, input logic exMemBub,
                              input logic start, input logic busy,
                              input logic [31:0] lc, input logic [31:0] mc,
                              input logic [31:0] expLc, input logic [31:0] expMc);
        checkOutput({tag, ".pc_en"},         32'(pc),       32'(e.pc));
        checkOutput({tag, ".if_id_en"},      32'(ifId),     32'(e.ifId));
        checkOutput({tag, ".id_ex_en"},      32'(idEx),     32'(e.idEx));
        checkOutput({tag, ".id_ex_bubble"},  32'(idExBub),  32'(e.idExBub));
        checkOutput({tag, ".ex_mem_bubble"}, 32'(exMemBub), 32'(e.exMemBub));
        checkOutput({tag, ".mult_start"},    32'(start),    32'(e.start));
        checkOutput({tag, ".mult_busy"},     32'(busy),     32'(e.busy));
        checkOutput({tag, ".load_stall_cnt"}, lc, STATS ? expLc : 32'd0);
        checkOutput({tag, ".mult_stall_cnt"}, mc, STATS ? expMc : 32'd0);
    endtask

    // Compare process. Outputs are sampled on the falling edge, with the
    // inputs steady since shortly after the previous rising edge.
    always @(negedge clk) begin
        exp_t e3, e1;
        e3 = modelStep(3, age3, loadHazardNow(), multEx, rst);
        e1 = modelStep(1, age1, loadHazardNow(), multEx, rst);
        compareDut("L3", e3, pcEn3, ifIdEn3, idExEn3, idExBub3, exMemBub3,
                   start3, busy3, loadCnt3, multCnt3, mLoad3, mMult3);
        compareDut("L1", e1, pcEn1, ifIdEn1, idExEn1, idExBub1, exMemBub1,
                   start1, busy1, loadCnt1, multCnt1, mLoad1, mMult1);
    end

    // Model state update at the active edge.
    always @(posedge clk) begin
        exp_t e3, e1;
        logic haz;
        haz = loadHazardNow();
        e3 = modelStep(3, age3, haz, multEx, rst);
        e1 = modelStep(1, age1, haz, multEx, rst);
        if (rst) begin
            age3 <= 5'd0; age1 <= 5'd0;
            mLoad3 <= 32'd0; mMult3 <= 32'd0; mLoad1 <= 32'd0; mMult1 <= 32'd0;
        end else begin
            age3 <= e3.nextAge;
            age1 <= e1.nextAge;
            if (haz && !e3.stallMult && mLoad3 != 32'hFFFF_FFFF) mLoad3 <= mLoad3 + 32'd1;
            if (e3.stallMult && mMult3 != 32'hFFFF_FFFF)         mMult3 <= mMult3 + 32'd1;
            if (haz && !e1.stallMult && mLoad1 != 32'hFFFF_FFFF) mLoad1 <= mLoad1 + 32'd1;
            if (e1.stallMult && mMult1 != 32'hFFFF_FFFF)         mMult1 <= mMult1 + 32'd1;
        end
    end

    // Drives one cycle of pipeline-field inputs.
    task automatic applyStimulus(input logic r,
                                 input logic [4:0] s1, input logic u1,
                                 input logic [4:0] s2, input logic u2,
                                 input logic [4:0] dEx, input logic wEx, input logic ldEx,
                                 input logic [4:0] dMem, input logic wMem, input logic ldMem,
                                 input logic mul);
        rst = r;
        rs1ID = s1; usesRs1 = u1; rs2ID = s2; usesRs2 = u2;
        rdEx = dEx; regWriteEx = wEx; memToRegEx = ldEx;
        rdMem = dMem; regWriteMem = wMem; memToRegMem = ldMem;
        multEx = mul;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idleInputs();
        rst = 1'b1;
        #1;
        // Reset behaviour.
        @(negedge clk);
        checkOutput("rst.pc_en", 32'(pcEn3), 32'd1);
        checkOutput("rst.mult_busy", 32'(busy3), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("rst.load_cnt", loadCnt3, 32'd0);
        checkOutput("rst.mult_cnt", multCnt3, 32'd0);
        nextCycle();

        // Load in EX, then in MEM, then in WB.
        applyStimulus(1'b0, 5'd5, 1'b1, 5'd9, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("ldex.c1.pc_en", 32'(pcEn3), 32'd0);
        checkOutput("ldex.c1.id_ex_bubble", 32'(idExBub3), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 5'd5, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("ldex.c2.pc_en", 32'(pcEn3), 32'd0);
        checkOutput("ldex.c2.id_ex_bubble", 32'(idExBub3), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 5'd5, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("ldex.c3.pc_en", 32'(pcEn3), 32'd1);
        checkOutput("ldex.c3.id_ex_bubble", 32'(idExBub3), 32'd0);
        nextCycle();

        // A load to x0 never stalls. Non-load writers and unused sources
        // do not stall either.
        applyStimulus(1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("ldx0.pc_en", 32'(pcEn3), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 5'd6, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd6, 1'b0, 5'd3, 1'b0, 5'd6, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("unused.pc_en", 32'(pcEn3), 32'd1);
        nextCycle();

        // Loads in both EX and MEM that match different sources.
        applyStimulus(1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("dual.c2.id_ex_bubble", 32'(idExBub3), 32'd1);
        nextCycle();
        idleInputs();
        nextCycle();

        // Multiply with L = 3, starting from fresh counters.
        rst = 1'b1;
        nextCycle();
        applyStimulus(1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("mul.c1.mult_start", 32'(start3), 32'd1);
        checkOutput("mul.c1.mult_busy", 32'(busy3), 32'd1);
        checkOutput("mul.c1.ex_mem_bubble", 32'(exMemBub3), 32'd1);
        checkOutput("mul1.c1.mult_start", 32'(start1), 32'd1);
        checkOutput("mul1.c1.mult_busy", 32'(busy1), 32'd0);
        checkOutput("mul1.c1.pc_en", 32'(pcEn1), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("mul.c2.mult_start", 32'(start3), 32'd0);
        checkOutput("mul.c2.mult_busy", 32'(busy3), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("mul.c3.pc_en", 32'(pcEn3), 32'd1);
        checkOutput("mul.c3.mult_busy", 32'(busy3), 32'd0);
        nextCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("mul.mult_cnt", multCnt3, STATS ? 32'd2 : 32'd0);
        nextCycle();

        // Multiply while a load in MEM feeds rs2.
        applyStimulus(1'b0, 5'd1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("mulld.c1.id_ex_bubble", 32'(idExBub3), 32'd0);
        checkOutput("mulld.c1.pc_en", 32'(pcEn3), 32'd0);
        checkOutput("mulld1.c1.id_ex_bubble", 32'(idExBub1), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 5'd1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        @(negedge clk);
        checkOutput("mulld.c3.pc_en", 32'(pcEn3), 32'd1);
        nextCycle();

        // Back-to-back multiplies: the second one starts in cycle 4.
        @(negedge clk);
        checkOutput("b2b.c4.mult_start", 32'(start3), 32'd1);
        nextCycle();
        nextCycle();
        idleInputs();
        nextCycle();

        // Reset in BUSY while cnt = 1.
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstbusy.pc_en", 32'(pcEn3), 32'd1);
        nextCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("rstbusy.mult_busy", 32'(busy3), 32'd0);
        checkOutput("rstbusy.id_ex_en", 32'(idExEn3), 32'd1);
        checkOutput("rstbusy.mult_cnt", multCnt3, 32'd0);
        nextCycle();
        nextCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
